// File: rtl/product_accumulator_pkg.sv
// Shared types and default widths for the streaming product accumulator.
package product_accumulator_pkg;

  localparam int DEF_PROD_W = 32;
  localparam int DEF_ACC_W  = 40;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/product_accumulator_sat_adder.sv
// Unsigned accumulate step: zero-extends the product, adds at ACC_W+1 bits
// and clamps to all ones when the carry out is set.
module sat_adder #(
  parameter int ACC_W  = 40,
  parameter int PROD_W = 32
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_add,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_ovf
);

  logic [ACC_W:0] w_full;

  assign w_full = {1'b0, i_acc} + {{(ACC_W+1-PROD_W){1'b0}}, i_add};
  assign o_ovf  = w_full[ACC_W];
  assign o_sum  = o_ovf ? {ACC_W{1'b1}} : w_full[ACC_W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Frame accumulator: sums frame_len unsigned products into a saturating
// accumulator and holds the total on a valid/ready output until taken.
module product_accumulator
  import product_accumulator_pkg::*;
#(
  parameter int PROD_W = DEF_PROD_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  logic [CNT_W-1:0]  i_frame_len,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [PROD_W-1:0] i_in_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [ACC_W-1:0]  o_out_data,
  output logic              o_out_sat,
  output logic              o_busy
);

  state_t             r_state;
  logic [CNT_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_acc;
  logic               r_sat;

  logic               w_beat;
  logic               w_take_start;
  logic [ACC_W-1:0]   w_sum;
  logic               w_ovf;

  sat_adder #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_sat_adder (
    .i_acc (r_acc),
    .i_add (i_in_data),
    .o_sum (w_sum),
    .o_ovf (w_ovf)
  );

  assign w_beat       = (r_state == ST_ACCUM) && i_in_valid;
  // Accepting the result and starting the next frame share one HOLD cycle.
  assign w_take_start = i_start &&
                        ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && i_out_ready));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_sat   <= 1'b0;
    end else if (w_take_start) begin
      r_len   <= i_frame_len;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_sat   <= 1'b0;
      r_state <= (i_frame_len != '0) ? ST_ACCUM : ST_HOLD;
    end else begin
      case (r_state)
        ST_ACCUM: begin
          if (w_beat) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + 1'b1;
            if (w_ovf) r_sat <= 1'b1;
            if (r_cnt == r_len - 1'b1) r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (i_out_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_in_ready  = (r_state == ST_ACCUM);
  assign o_out_valid = (r_state == ST_HOLD);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_out_data  = r_acc;
  assign o_out_sat   = r_sat;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed + randomized bench for product_accumulator; a 40-bit and a 34-bit
// instance share stimulus and are checked against a plain-arithmetic model.
module tb_product_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start, i_in_valid, i_out_ready;
  logic [7:0]  i_frame_len;
  logic [31:0] i_in_data;

  logic        a_in_ready, a_out_valid, a_out_sat, a_busy;
  logic [39:0] a_out_data;
  logic        b_in_ready, b_out_valid, b_out_sat, b_busy;
  logic [33:0] b_out_data;

  int n_total = 0;
  int n_pass  = 0;
  logic [31:0] cur[$];
  int          gaps[$];

  always #5 clk = ~clk;

  product_accumulator u_dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_frame_len(i_frame_len),
    .i_in_valid(i_in_valid), .o_in_ready(a_in_ready), .i_in_data(i_in_data),
    .o_out_valid(a_out_valid), .i_out_ready(i_out_ready),
    .o_out_data(a_out_data), .o_out_sat(a_out_sat), .o_busy(a_busy)
  );

  product_accumulator #(.ACC_W(34)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_frame_len(i_frame_len),
    .i_in_valid(i_in_valid), .o_in_ready(b_in_ready), .i_in_data(i_in_data),
    .o_out_valid(b_out_valid), .i_out_ready(i_out_ready),
    .o_out_data(b_out_data), .o_out_sat(b_out_sat), .o_busy(b_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Frame total = true sum clamped to the accumulator range; sat when clamped.
  task automatic model(input int accw, output logic [63:0] sum, output logic sat);
    longint unsigned s = 0;
    longint unsigned mx = (64'd1 << accw) - 1;
    foreach (cur[i]) s += cur[i];
    sat = (s > mx);
    sum = sat ? mx : s;
  endtask

  task automatic chk_ctl(input string tag, input logic busy, input logic rdy, input logic vld);
    chk({tag, "_busy_a"}, a_busy, busy);      chk({tag, "_busy_b"}, b_busy, busy);
    chk({tag, "_in_ready_a"}, a_in_ready, rdy); chk({tag, "_in_ready_b"}, b_in_ready, rdy);
    chk({tag, "_out_valid_a"}, a_out_valid, vld); chk({tag, "_out_valid_b"}, b_out_valid, vld);
  endtask

  task automatic chk_result(input string tag);
    logic [63:0] s; logic st;
    model(40, s, st);
    chk({tag, "_data_a"}, a_out_data, s); chk({tag, "_sat_a"}, a_out_sat, st);
    model(34, s, st);
    chk({tag, "_data_b"}, b_out_data, s); chk({tag, "_sat_b"}, b_out_sat, st);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input logic [7:0] len);
    i_start = 1'b1; i_frame_len = len;
    tick();
    i_start = 1'b0; i_frame_len = $urandom;
    chk_ctl("start", 1'b1, len != 0, len == 0);
    chk("start_clr_a", a_out_data, 0); chk("start_clr_b", b_out_data, 0);
  endtask

  // gaps[i] idle cycles precede beat i; the beat after the last must be HOLD.
  task automatic feed();
    foreach (cur[i]) begin
      repeat (gaps[i]) begin
        i_in_valid = 1'b0; i_in_data = $urandom;
        tick();
        chk("bubble_in_ready_a", a_in_ready, 1'b1);
      end
      i_in_valid = 1'b1; i_in_data = cur[i];
      tick();
      i_in_valid = 1'b0;
      if (i == cur.size() - 1) chk_ctl("last_beat", 1'b1, 1'b0, 1'b1);
      else chk("mid_in_ready_a", a_in_ready, 1'b1);
    end
  endtask

  task automatic hold(input int cycles);
    repeat (cycles) begin
      i_out_ready = 1'b0; i_in_valid = 1'b1; i_in_data = $urandom;
      tick();
      chk_ctl("hold", 1'b1, 1'b0, 1'b1);
      chk_result("hold");
    end
    i_in_valid = 1'b0;
  endtask

  task automatic drain();
    i_out_ready = 1'b1;
    tick();
    i_out_ready = 1'b0;
    chk_ctl("drain", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic set_frame(input int n, input logic [31:0] val, input bit rnd_data, input int gmax);
    cur.delete(); gaps.delete();
    for (int i = 0; i < n; i++) begin
      cur.push_back(rnd_data ? $urandom : val);
      gaps.push_back($urandom_range(gmax, 0));
    end
  endtask

  initial begin
    rst_n = 1'b0; i_start = 1'b0; i_frame_len = '0; i_in_valid = 1'b0;
    i_in_data = '0; i_out_ready = 1'b0;
    #12;
    chk_ctl("reset", 1'b0, 1'b0, 1'b0);
    chk("reset_data_a", a_out_data, 0); chk("reset_sat_a", a_out_sat, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();

    // Basic 4-beat frame.
    set_frame(0, 0, 0, 0);
    cur = '{32'd10, 32'd20, 32'd30, 32'd40}; gaps = '{0, 0, 0, 0};
    do_start(8'd4); feed(); chk_result("basic");
    chk("basic_100", a_out_data, 64'd100);
    hold(2); drain();

    // Bubbles: valid pattern 1,0,0,1,0,1.
    cur = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}; gaps = '{0, 2, 1};
    do_start(8'd3); feed(); chk_result("bubble");
    chk("bubble_const", a_out_data, 64'h2_FFFF_FFFD);
    hold(1); drain();

    // Max frame of all-ones: wide instance exact, narrow instance clamps.
    set_frame(255, 32'hFFFF_FFFF, 0, 0);
    do_start(8'd255); feed(); chk_result("max_frame");
    chk("max_frame_const", a_out_data, 64'hFE_FFFF_FF01);
    drain();

    // 8 all-ones beats saturate the 34-bit instance; then backpressure.
    set_frame(8, 32'hFFFF_FFFF, 0, 1);
    do_start(8'd8); feed(); chk_result("sat8");
    chk("sat8_b_const", b_out_data, 64'h3_FFFF_FFFF); chk("sat8_b_flag", b_out_sat, 1'b1);
    hold(5);

    // Accept and restart in the same cycle.
    i_out_ready = 1'b1; i_start = 1'b1; i_frame_len = 8'd2;
    tick();
    i_out_ready = 1'b0; i_start = 1'b0;
    chk_ctl("b2b", 1'b1, 1'b1, 1'b0);
    chk("b2b_clr_a", a_out_data, 0); chk("b2b_sat_clr_b", b_out_sat, 0);
    cur = '{32'd7, 32'd8}; gaps = '{0, 0};
    feed(); chk_result("b2b"); chk("b2b_15", a_out_data, 64'd15);
    drain();

    // Zero-length frame.
    cur.delete(); gaps.delete();
    do_start(8'd0); chk_result("zero");
    hold(2); drain();

    // start held high through ACCUM and HOLD(out_ready=0) is ignored.
    set_frame(3, 0, 1, 2);
    do_start(8'd3);
    i_start = 1'b1; i_frame_len = 8'd1;
    feed(); chk_result("ign");
    hold(2);
    i_start = 1'b0;
    drain();

    // Randomized frames.
    for (int f = 0; f < 8; f++) begin
      int n = $urandom_range(20, 1);
      set_frame(n, 0, 1, 2);
      do_start(8'(n)); feed(); chk_result("rand");
      hold($urandom_range(3, 0)); drain();
    end

    // Asynchronous reset mid-frame with acc = 0x1234.
    do_start(8'd5);
    i_in_valid = 1'b1; i_in_data = 32'h1000; tick();
    i_in_data = 32'h234; tick();
    i_in_valid = 1'b0;
    chk("pre_reset_acc", a_out_data, 64'h1234);
    #2 rst_n = 1'b0;
    #1;
    chk_ctl("async_rst", 1'b0, 1'b0, 1'b0);
    chk("async_rst_data_a", a_out_data, 0); chk("async_rst_data_b", b_out_data, 0);
    chk("async_rst_sat_a", a_out_sat, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    chk_ctl("post_rst", 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
